// File: rtl/rr_burst_arbiter.sv
// N-input round-robin arbiter with a registered one-hot grant that stays locked to its
// owner until the transaction ends, the owner withdraws, or the burst cap is reached.
module rr_burst_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 8,
    parameter int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     req_last,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             dbg_state_o,
    output logic [IDX_W-1:0] dbg_ptr_o
);
    localparam int BC_W     = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int CAP_LAST = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [BC_W-1:0]  beat_q, beat_d;

    logic [IDX_W-1:0] base, win, nxt_ptr;
    logic [N-1:0]     win_oh;
    logic [2*N-1:0]   req_rot;
    logic             found, at_cap, owner_req, owner_last, release_now;

    // grant_q is one-hot on the owner, so masking avoids a variable index into req.
    assign owner_req   = |(req & grant_q);
    assign owner_last  = |(req_last & grant_q);
    assign at_cap      = (MAX_BURST != 0) && (beat_q == BC_W'(CAP_LAST));
    assign release_now = (state_q == OWNED) &&
                         (!owner_req || (advance && owner_last) || (advance && at_cap));
    assign nxt_ptr     = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
    assign base        = release_now ? nxt_ptr : ptr_q;
    assign req_rot     = {req, req} >> base;

    // Rotate so that bit 0 is the highest-priority requester, then map back modulo N.
    always_comb begin
        int s;
        found = 1'b0;
        win   = '0;
        s     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                s     = int'(base) + i;
                if (s >= N) s = s - N;
                win   = IDX_W'(s);
            end
        end
        for (int i = 0; i < N; i++) begin
            win_oh[i] = (win == IDX_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win_oh;
                    idx_d   = win;
                    beat_d  = '0;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (release_now) begin
                    ptr_d  = nxt_ptr;
                    beat_d = '0;
                    if (found) begin
                        grant_d = win_oh;
                        idx_d   = win;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (advance && (MAX_BURST != 0)) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = |grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: two instances (N=4/cap 4 and N=3/unlimited)
// checked every cycle against an integer-level arbitration model plus literal checkpoints.
module tb_rr_burst_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // Instance A: N=4, MAX_BURST=4
  logic [3:0] a_req, a_last, a_grant;
  logic a_adv, a_valid, a_dstate;
  logic [1:0] a_idx, a_dptr;
  // Instance B: N=3, MAX_BURST=0
  logic [2:0] b_req, b_last, b_grant;
  logic b_adv, b_valid, b_dstate;
  logic [1:0] b_idx, b_dptr;

  rr_burst_arbiter #(.N(4), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .req_last(a_last), .advance(a_adv),
    .grant(a_grant), .grant_valid(a_valid), .grant_idx(a_idx),
    .dbg_state_o(a_dstate), .dbg_ptr_o(a_dptr)
  );

  rr_burst_arbiter #(.N(3), .MAX_BURST(0)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .req_last(b_last), .advance(b_adv),
    .grant(b_grant), .grant_valid(b_valid), .grant_idx(b_idx),
    .dbg_state_o(b_dstate), .dbg_ptr_o(b_dptr)
  );

  // ---------------- model ----------------
  typedef struct {
    int n;
    int mb;
    int owner;
    int ptr;
    int beats;
    int idx;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(int n, int cap);
    mdl_t m;
    m.n = n; m.mb = cap; m.owner = -1; m.ptr = 0; m.beats = 0; m.idx = 0;
    return m;
  endfunction

  function automatic bit bit_of(logic [31:0] v, int i);
    return ((v >> i) & 32'd1) != 32'd0;
  endfunction

  function automatic int pick(int n, logic [31:0] r, int p);
    for (int k = 0; k < n; k++) begin
      if (bit_of(r, (p + k) % n)) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic mdl_t step(mdl_t m, logic [31:0] r, logic [31:0] l, logic adv);
    mdl_t s;
    int w;
    bit rel;
    s = m;
    if (s.owner < 0) begin
      w = pick(s.n, r, s.ptr);
      if (w >= 0) begin
        s.owner = w; s.idx = w; s.beats = 0;
      end
    end else begin
      rel = !bit_of(r, s.owner) || (adv && bit_of(l, s.owner)) ||
            (adv && s.mb != 0 && s.beats + 1 == s.mb);
      if (rel) begin
        s.ptr = (s.owner + 1) % s.n;
        s.beats = 0;
        w = pick(s.n, r, s.ptr);
        s.owner = w;
        if (w >= 0) s.idx = w;
      end else if (adv) begin
        s.beats = s.beats + 1;
      end
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_grant(mdl_t m);
    return (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mdl_reset(4, 4);
      mb <= mdl_reset(3, 0);
    end else begin
      ma <= step(ma, 32'(a_req), 32'(a_last), a_adv);
      mb <= step(mb, 32'(b_req), 32'(b_last), b_adv);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && rst === 1'b0) begin
      chk("a_grant", 32'(a_grant), exp_grant(ma));
      chk("a_valid", 32'(a_valid), 32'(ma.owner >= 0));
      chk("a_idx", 32'(a_idx), 32'(ma.idx));
      chk("a_ptr", 32'(a_dptr), 32'(ma.ptr));
      chk("a_state", 32'(a_dstate), 32'(ma.owner >= 0));
      chk("b_grant", 32'(b_grant), exp_grant(mb));
      chk("b_valid", 32'(b_valid), 32'(mb.owner >= 0));
      chk("b_idx", 32'(b_idx), 32'(mb.idx));
      chk("b_ptr", 32'(b_dptr), 32'(mb.ptr));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick_a(input logic [3:0] r, input logic [3:0] l, input logic adv);
    a_req = r; a_last = l; a_adv = adv;
    @(negedge clk);
  endtask

  task automatic tick_b(input logic [2:0] r, input logic [2:0] l, input logic adv);
    b_req = r; b_last = l; b_adv = adv;
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_req = '0; a_last = '0; a_adv = 1'b0;
    b_req = '0; b_last = '0; b_adv = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    a_req = '0; a_last = '0; a_adv = 1'b0;
    b_req = '0; b_last = '0; b_adv = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b1;

    // reset values
    chk("rst_a_grant", 32'(a_grant), 32'h0);
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    chk("rst_a_idx", 32'(a_idx), 32'h0);
    chk("rst_b_grant", 32'(b_grant), 32'h0);

    // latency 1, then withdrawal to idle keeps last index
    tick_a(4'b1010, 4'b0000, 1'b0);
    chk("lat_grant", 32'(a_grant), 32'h2);
    chk("lat_idx", 32'(a_idx), 32'h1);
    chk("lat_valid", 32'(a_valid), 32'h1);
    tick_a(4'b0000, 4'b0000, 1'b0);
    chk("idle_grant", 32'(a_grant), 32'h0);
    chk("idle_idx_hold", 32'(a_idx), 32'h1);
    chk("idle_ptr", 32'(a_dptr), 32'h2);

    // rotation with req_last every beat
    do_reset();
    tick_a(4'b1111, 4'b1111, 1'b1);
    chk("rot0", 32'(a_grant), 32'h1);
    tick_a(4'b1111, 4'b1111, 1'b1);
    chk("rot1", 32'(a_grant), 32'h2);
    tick_a(4'b1111, 4'b1111, 1'b1);
    chk("rot2", 32'(a_grant), 32'h4);
    tick_a(4'b1111, 4'b1111, 1'b1);
    chk("rot3", 32'(a_grant), 32'h8);
    tick_a(4'b1111, 4'b1111, 1'b1);
    chk("rot4", 32'(a_grant), 32'h1);

    // burst cap of 4 beats between two requesters
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick_a(4'b0011, 4'b0000, 1'b1);
      chk("cap_seq", 32'(a_grant), (k < 4) ? 32'h1 : ((k < 8) ? 32'h2 : 32'h1));
    end

    // cap, last and withdrawal all at once: a single release
    do_reset();
    for (int k = 0; k < 4; k++) tick_a(4'b0011, 4'b0000, 1'b1);
    chk("combo_pre", 32'(a_grant), 32'h1);
    tick_a(4'b0010, 4'b0001, 1'b1);
    chk("combo_grant", 32'(a_grant), 32'h2);
    chk("combo_ptr", 32'(a_dptr), 32'h1);
    tick_a(4'b0010, 4'b0000, 1'b1);

    // sole requester at cap is re-granted without a gap
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick_a(4'b0001, 4'b0000, 1'b1);
      chk("sole_grant", 32'(a_grant), 32'h1);
      chk("sole_valid", 32'(a_valid), 32'h1);
    end

    // withdrawal hands over from ptr 3, then ptr wraps to 0
    do_reset();
    tick_a(4'b0100, 4'b0000, 1'b0);
    chk("wd_owner", 32'(a_grant), 32'h4);
    tick_a(4'b1001, 4'b0000, 1'b0);
    chk("wd_grant", 32'(a_grant), 32'h8);
    chk("wd_ptr", 32'(a_dptr), 32'h3);
    tick_a(4'b1001, 4'b1000, 1'b1);
    chk("wd_wrap_grant", 32'(a_grant), 32'h1);
    chk("wd_wrap_ptr", 32'(a_dptr), 32'h0);

    // asynchronous reset between edges, mid-burst
    do_reset();
    tick_a(4'b0010, 4'b0000, 1'b0);
    chk("ar_pre", 32'(a_grant), 32'h2);
    tick_a(4'b0010, 4'b0000, 1'b1);
    a_req = 4'b1111; a_adv = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("ar_grant", 32'(a_grant), 32'h0);
    chk("ar_valid", 32'(a_valid), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ar_after", 32'(a_grant), 32'h1);

    // N=3 unlimited burst, then wrap 2 -> 0
    do_reset();
    tick_b(3'b111, 3'b000, 1'b1);
    chk("b_first", 32'(b_grant), 32'h1);
    for (int k = 0; k < 20; k++) begin
      tick_b(3'b111, 3'b000, 1'b1);
      chk("b_hold", 32'(b_grant), 32'h1);
    end
    tick_b(3'b111, 3'b001, 1'b1);
    chk("b_next", 32'(b_grant), 32'h2);
    chk("b_ptr1", 32'(b_dptr), 32'h1);
    tick_b(3'b111, 3'b010, 1'b1);
    chk("b_last_req", 32'(b_grant), 32'h4);
    chk("b_ptr2", 32'(b_dptr), 32'h2);
    tick_b(3'b111, 3'b100, 1'b1);
    chk("b_wrap_grant", 32'(b_grant), 32'h1);
    chk("b_wrap_ptr", 32'(b_dptr), 32'h0);
    tick_b(3'b000, 3'b000, 1'b0);
    chk("b_idle", 32'(b_valid), 32'h0);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
